// File: rtl/arb_pkg.sv
// Shared types and default widths for the cacheline memory arbiter.
// Both caches use this port to memory.
package arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_RD   = 3'd1,
    ST_D_RD   = 3'd2,
    ST_D_WR   = 3'd3,
    ST_I_DONE = 3'd4,
    ST_D_DONE = 3'd5
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. This block is combinational only.
// The arbiter holds last_grant and updates it when it commits a grant.
module rr_pick2
  import arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = req_i | req_d;
    grant = GRANT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Lets the I-cache and D-cache miss paths share one memory cacheline port.
// It handles one transaction at a time and grants round-robin when both caches request.
module cacheline_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = arb_pkg::ADDR_W,
  parameter int LINE_W = arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  grant_t pick_grant;
  logic   pick_valid;

  rr_pick2 u_pick (
    .req_i      (i_read),
    .req_d      (d_read | d_write),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_grant;
          if (pick_grant == GRANT_I) begin
            state_d = ST_I_RD;
            addr_d  = i_addr;
          end else begin
            addr_d = d_addr;
            // A simultaneous read and write is illegal. The write takes priority.
            if (d_write) begin
              state_d = ST_D_WR;
              wdata_d = d_wdata;
            end else begin
              state_d = ST_D_RD;
            end
          end
        end
      end
      ST_I_RD: begin
        if (mem_resp) begin
          i_rdata_d = mem_rdata;
          state_d   = ST_I_DONE;
        end
      end
      ST_D_RD: begin
        if (mem_resp) begin
          d_rdata_d = mem_rdata;
          state_d   = ST_D_DONE;
        end
      end
      ST_D_WR: begin
        if (mem_resp) state_d = ST_D_DONE;
      end
      ST_I_DONE, ST_D_DONE: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs decode the state register and latches directly, so reset clears them at once.
  assign mem_read  = (state_q == ST_I_RD) || (state_q == ST_D_RD);
  assign mem_write = (state_q == ST_D_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_resp    = (state_q == ST_I_DONE);
  assign d_resp    = (state_q == ST_D_DONE);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_read && d_write))
    else $error("d_read and d_write asserted together; write granted");

  a_resp_in_txn: assert property (@(posedge clk) disable iff (!rst_n)
    mem_resp |-> (state_q inside {ST_I_RD, ST_D_RD, ST_D_WR}))
    else $warning("mem_resp with no transaction outstanding; ignored");

endmodule
